// File: rtl/controle_pilha_pkg.sv
// Shared opcode map, state encoding and error codes for the stack/ALU controller.
// The datapath imports the same package so both sides agree on opcode meaning.
package controle_pilha_pkg;

    localparam logic [4:0] OP_PUSH_D = 5'b00000;
    localparam logic [4:0] OP_PUSH_I = 5'b00001;
    localparam logic [4:0] OP_PUSH_T = 5'b00010;
    localparam logic [4:0] OP_POP    = 5'b00011;
    localparam logic [4:0] OP_ADD    = 5'b00100;

    // Lower bound of each opcode class; each class runs up to the next bound.
    localparam logic [4:0] OP_BIN_LO = 5'b00100;
    localparam logic [4:0] OP_UN_LO  = 5'b10000;
    localparam logic [4:0] OP_ILL_LO = 5'b11000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POP1,
        ST_WAIT1,
        ST_LD1,
        ST_POP2,
        ST_WAIT2,
        ST_LD2,
        ST_PUSH,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_UNDERFLOW = 2'b01,
        ERR_OVERFLOW  = 2'b10,
        ERR_ILLEGAL   = 2'b11
    } err_e;

    typedef enum logic [2:0] {
        CL_PUSH,
        CL_POP,
        CL_BINARY,
        CL_UNARY,
        CL_ILLEGAL
    } op_class_e;

    function automatic op_class_e classify(input logic [4:0] op);
        if (op < OP_POP)         return CL_PUSH;
        else if (op == OP_POP)   return CL_POP;
        else if (op < OP_UN_LO)  return CL_BINARY;
        else if (op < OP_ILL_LO) return CL_UNARY;
        else                     return CL_ILLEGAL;
    endfunction

endpackage

// File: rtl/controle_pilha_contador_espera.sv
// Loadable down-counter timing the settle gap between a stack pop and the
// operand load. Counts down to zero and holds there.
module contador_espera #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments; the reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/controle_pilha.sv
// Sequencing FSM for the stack/ALU datapath: turns one accepted opcode into the
// pop -> load -> push strobe sequence and reports underflow/overflow/illegal.
module controle_pilha
    import controle_pilha_pkg::*;
#(
    parameter int POP_LAT = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [4:0] opcode,
    input  logic       empty,
    input  logic       full,
    output logic       pop,
    output logic       push,
    output logic       load,
    output logic       load_sel,
    output logic [4:0] opcode_q,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam logic [1:0] WAIT_INIT = (POP_LAT > 0) ? 2'(POP_LAT - 1) : 2'd0;

    state_e     state_q, state_d;
    logic [4:0] opcode_d;
    err_e       err_code_d;
    logic       cnt_zero;
    logic       cnt_load;

    // The pop is loaded every time; WAIT only ever follows a POPn state.
    assign cnt_load = (state_q == ST_POP1) || (state_q == ST_POP2);

    contador_espera #(.W(2)) u_contador_espera (
        .clk      (clk),
        .rstn     (rstn),
        .load     (cnt_load),
        .load_val (WAIT_INIT),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        err_code_d = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opcode_d = opcode;
                    case (classify(opcode))
                        CL_PUSH:    state_d = ST_PUSH;
                        CL_ILLEGAL: begin
                            state_d    = ST_DONE;
                            err_code_d = ERR_ILLEGAL;
                        end
                        default:    state_d = ST_POP1;
                    endcase
                end
            end
            ST_POP1: begin
                if (empty) begin
                    state_d    = ST_DONE;
                    err_code_d = ERR_UNDERFLOW;
                end else if (opcode_q == OP_POP) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = (POP_LAT == 0) ? ST_LD1 : ST_WAIT1;
                end
            end
            ST_WAIT1: if (cnt_zero) state_d = ST_LD1;
            ST_LD1:   state_d = (classify(opcode_q) == CL_BINARY) ? ST_POP2 : ST_PUSH;
            ST_POP2: begin
                if (empty) begin
                    state_d    = ST_DONE;
                    err_code_d = ERR_UNDERFLOW;
                end else begin
                    state_d = (POP_LAT == 0) ? ST_LD2 : ST_WAIT2;
                end
            end
            ST_WAIT2: if (cnt_zero) state_d = ST_LD2;
            ST_LD2:   state_d = ST_PUSH;
            ST_PUSH: begin
                state_d = ST_DONE;
                if (full) err_code_d = ERR_OVERFLOW;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
            load     <= 1'b0;
            load_sel <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            load     <= (state_d == ST_LD1) || (state_d == ST_LD2);
            load_sel <= (state_d == ST_LD2);
            busy     <= (state_d != ST_IDLE);
            done     <= (state_d == ST_DONE);
            err      <= (state_d == ST_DONE) && (err_code_d != ERR_NONE);
            err_code <= (state_d == ST_DONE) ? err_code_d : ERR_NONE;
        end
    end

    // Stack strobes are gated by the live flags so a blocked pop/push never fires.
    assign pop  = ((state_q == ST_POP1) || (state_q == ST_POP2)) && !empty;
    assign push = (state_q == ST_PUSH) && !full;

endmodule

// File: tb/tb_controle_pilha.sv
// Directed bench for controle_pilha with a small stack/ALU datapath model.
// A second instance with POP_LAT=0 checks the shortened binary sequence.
module tb_controle_pilha;
    import controle_pilha_pkg::*;

    logic       clk = 1'b0;
    logic       rstn, start, force_full;
    logic [4:0] opcode;
    logic       empty, full;
    logic       pop, push, load, load_sel, busy, done, err;
    logic [4:0] opcode_q;
    logic [1:0] err_code;

    logic       start0;
    logic [4:0] opcode0;
    logic       empty0 = 1'b0;
    logic       full0  = 1'b0;
    logic       pop0, push0, load0, load_sel0, busy0, done0, err0;
    logic [4:0] opcode_q0;
    logic [1:0] err_code0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    controle_pilha #(.POP_LAT(1)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .opcode(opcode),
        .empty(empty), .full(full), .pop(pop), .push(push), .load(load),
        .load_sel(load_sel), .opcode_q(opcode_q), .busy(busy), .done(done),
        .err(err), .err_code(err_code)
    );

    controle_pilha #(.POP_LAT(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .start(start0), .opcode(opcode0),
        .empty(empty0), .full(full0), .pop(pop0), .push(push0), .load(load0),
        .load_sel(load_sel0), .opcode_q(opcode_q0), .busy(busy0), .done(done0),
        .err(err0), .err_code(err_code0)
    );

    // Datapath model: 4-deep stack, pop register, tmp1/tmp2, ALU (ADD, unary = pass).
    logic [2:0] cnt;
    logic [7:0] stk [4];
    logic [7:0] pop_data, tmp1, tmp2, imm, push_val;

    assign empty = (cnt == 3'd0);
    assign full  = (cnt == 3'd4) || force_full;

    always_comb begin
        if (opcode_q < OP_POP)        push_val = imm;
        else if (opcode_q == OP_ADD)  push_val = tmp1 + tmp2;
        else                          push_val = tmp1;
    end

    always @(posedge clk) begin
        if (!rstn) begin
            cnt <= 3'd0;
        end else begin
            if (pop) begin
                pop_data <= stk[2'(cnt - 3'd1)];
                cnt      <= cnt - 3'd1;
            end
            if (load) begin
                if (load_sel) tmp2 <= pop_data;
                else          tmp1 <= pop_data;
            end
            if (push) begin
                stk[cnt[1:0]] <= push_val;
                cnt           <= cnt + 3'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] pop_m, load_m, lsel_m, push_m, busy_m;
    int          done_c;
    logic        err_s;
    logic [1:0]  code_s;

    // Issue one instruction and record per-cycle strobes for 12 cycles.
    task automatic run(input logic [4:0] op, input int glitch_cyc, input int rst_cyc);
        pop_m = '0; load_m = '0; lsel_m = '0; push_m = '0; busy_m = '0;
        done_c = 0; err_s = 1'b0; code_s = 2'b00;
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            pop_m[c]  = pop;
            load_m[c] = load;
            lsel_m[c] = load && load_sel;
            push_m[c] = push;
            busy_m[c] = busy;
            if (done && done_c == 0) begin
                done_c = c;
                err_s  = err;
                code_s = err_code;
            end
            if (c == 1) start = 1'b0;
            if (c == glitch_cyc) begin
                start  = 1'b1;
                opcode = OP_PUSH_I;
            end else if (c == glitch_cyc + 1) begin
                start = 1'b0;
            end
            if (c == rst_cyc) rstn = 1'b0;
            else if (c == rst_cyc + 1) rstn = 1'b1;
        end
    endtask

    task automatic push_imm(input logic [7:0] v);
        imm = v;
        run(OP_PUSH_I, 0, 0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b1; opcode = OP_PUSH_I; force_full = 1'b0; imm = '0;
        start0 = 1'b0; opcode0 = '0;

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {pop, push, load, load_sel, busy, done, err, err_code, opcode_q}, 32'd0);
        rstn = 1'b1; start = 1'b0;
        @(negedge clk);
        check("reset_release_busy", {busy, done}, 32'd0);

        push_imm(8'd12);
        check("push_i_push", push_m, 16'h0002);
        check("push_i_done", done_c, 2);
        check("push_i_err", err_s, 0);
        check("push_i_pop_load", pop_m | load_m, 16'h0000);
        check("push_i_busy", busy_m, 16'h0006);
        check("push_i_opcode_q", opcode_q, OP_PUSH_I);
        push_imm(8'd15);
        check("push_i2_depth", cnt, 2);

        run(OP_ADD, 0, 0);
        check("add_pop", pop_m, 16'h0012);
        check("add_load", load_m, 16'h0048);
        check("add_load_sel", lsel_m, 16'h0040);
        check("add_push", push_m, 16'h0080);
        check("add_busy", busy_m, 16'h01FE);
        check("add_done", done_c, 8);
        check("add_err", err_s, 0);
        check("add_depth", cnt, 1);
        check("add_top", stk[0], 27);

        run(5'b10000, 0, 0);
        check("unary_pop", pop_m, 16'h0002);
        check("unary_load", load_m, 16'h0008);
        check("unary_push", push_m, 16'h0010);
        check("unary_done", done_c, 5);
        check("unary_top", stk[0], 27);

        run(OP_ADD, 0, 0);
        check("under_pop", pop_m, 16'h0002);
        check("under_push", push_m, 16'h0000);
        check("under_done", done_c, 5);
        check("under_err", {err_s, code_s}, {1'b1, ERR_UNDERFLOW});
        check("under_depth", cnt, 0);

        force_full = 1'b1;
        imm = 8'd9;
        run(OP_PUSH_D, 0, 0);
        force_full = 1'b0;
        check("over_push", push_m, 16'h0000);
        check("over_done", done_c, 2);
        check("over_err", {err_s, code_s}, {1'b1, ERR_OVERFLOW});

        run(5'b11010, 0, 0);
        check("illegal_strobes", pop_m | load_m | push_m, 16'h0000);
        check("illegal_done", done_c, 1);
        check("illegal_err", {err_s, code_s}, {1'b1, ERR_ILLEGAL});
        check("illegal_opcode_q", opcode_q, 5'b11010);

        push_imm(8'd3);
        push_imm(8'd4);
        run(OP_ADD, 3, 0);
        check("glitch_done", done_c, 8);
        check("glitch_push", push_m, 16'h0080);
        check("glitch_opcode_q", opcode_q, OP_ADD);
        check("glitch_top", {cnt, stk[0]}, {3'd1, 8'd7});

        run(OP_POP, 0, 0);
        check("pop_pop", pop_m, 16'h0002);
        check("pop_done", {done_c[7:0], 7'd0, err_s}, {8'd2, 8'd0});

        push_imm(8'd1);
        push_imm(8'd2);
        run(OP_ADD, 0, 4);
        check("rst_mid_pop", pop_m, 16'h0012);
        check("rst_mid_load", load_m, 16'h0008);
        check("rst_mid_push", push_m, 16'h0000);
        check("rst_mid_busy", busy_m, 16'h001E);
        check("rst_mid_done", done_c, 0);
        check("rst_mid_opcode_q", opcode_q, 0);

        pop_m = '0; load_m = '0; push_m = '0; done_c = 0;
        @(negedge clk);
        start0  = 1'b1;
        opcode0 = OP_ADD;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start0    = 1'b0;
            pop_m[c]  = pop0;
            load_m[c] = load0;
            push_m[c] = push0;
            if (done0 && done_c == 0) done_c = c;
        end
        check("lat0_pop", pop_m, 16'h000A);
        check("lat0_load", load_m, 16'h0014);
        check("lat0_push", push_m, 16'h0020);
        check("lat0_done", done_c, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/controle_pilha.md
Name: controle_pilha

Overview:
- Sequencing FSM for the stack/ALU datapath (stack with push/pop/empty/full, tmp1/tmp2 operand registers, 5-bit-opcode ULA).
- Accepts one instruction per start handshake. Generates the pop -> load -> push sequence that the datapath needs, in the right order and with the right gaps.
- Flags stack underflow, stack overflow and illegal opcodes.
- Sits between the instruction source (fetch/decoder, or a bench) and the datapath control inputs.

Parameters:
- POP_LAT, 1, number of idle cycles between a pop pulse and the following load (stack output settle time); legal range 0..3.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  synchronous active-low reset.
- start  input  1  request to execute opcode; sampled only in IDLE.
- opcode  input  5  instruction opcode.
- empty  input  1  stack empty flag from datapath.
- full  input  1  stack full flag from datapath.
- pop  output  1  one-cycle stack pop strobe.
- push  output  1  one-cycle stack push strobe.
- load  output  1  one-cycle operand-register load strobe.
- load_sel  output  1  0 = load tmp1, 1 = load tmp2; valid while load=1.
- opcode_q  output  5  latched opcode driven to the ULA/mux; stable for the whole instruction.
- busy  output  1  high from the cycle after accept until and including the done cycle.
- done  output  1  one-cycle completion pulse.
- err  output  1  qualifies done: the instruction aborted.
- err_code  output  2  00 none, 01 underflow, 10 overflow, 11 illegal opcode; valid with done.

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE, all outputs 0 (including opcode_q). Reset mid-instruction aborts immediately and emits no done.
- Opcode classes:
  - 00000 PUSH_D, 00001 PUSH_I, 00010 PUSH_T: push class.
  - 00011 POP: discard top of stack.
  - 00100..01111: binary ALU op (two operands).
  - 10000..10111: unary ALU op (one operand).
  - 11000..11111: illegal.
- Accept: in IDLE with start=1 at an edge, latch opcode_q and leave IDLE. start is ignored while busy=1.
- States: IDLE, POP1, WAIT1, LD1, POP2, WAIT2, LD2, PUSH, DONE. WAITn lasts POP_LAT cycles, driven by a counter; it is skipped when POP_LAT=0.
- Sequences after accept (cycle 1 = first cycle after the accept edge):
  - push class: PUSH, DONE.
  - POP: POP1, DONE.
  - unary: POP1, WAIT1, LD1(load_sel=0), PUSH, DONE.
  - binary: POP1, WAIT1, LD1(load_sel=0), POP2, WAIT2, LD2(load_sel=1), PUSH, DONE.
  - illegal: DONE with err=1, err_code=11; no strobes.
- All strobes are Moore outputs, each high for exactly one cycle.
  - pop = (POPn and not empty).
  - push = (PUSH and not full).
  - load = LDn.
- Underflow: empty=1 in POP1 or POP2 → pop stays low, next state DONE, err=1, err_code=01. Operands already popped are not restored.
- Overflow: full=1 in PUSH → push stays low, next state DONE, err=1, err_code=10. For ALU ops this cannot occur after a pop, but the check is still made.
- DONE: done=1 and busy=1 for one cycle, then IDLE. Next accept possible on the edge ending DONE+1, i.e. start must be sampled in IDLE.
- Latency with POP_LAT=1, start sampled at edge 0:
  - push class: push in cycle 1, done in cycle 2.
  - unary: done in cycle 5.
  - binary: pop in c1 and c4, load in c3 and c6, push in c7, done in c8.
- General binary length: 6 + 2*POP_LAT cycles to done.
- opcode_q holds its value through DONE and persists in IDLE until the next accept.

Decomposition:
- Shared include file (defines) holds:
  - opcode constants: OP_PUSH_D, OP_PUSH_I, OP_PUSH_T, OP_POP, OP_ADD = 5'b00100, class range bounds;
  - state encodings;
  - err_code values.
  - The datapath and this controller both use it.
- One natural sub-module: contador_espera, a loadable down-counter that implements the WAITn delay (load POP_LAT, assert zero flag).

Test Plan:
- Reset: hold rstn=0 for 3 cycles with start=1 → every output 0, busy=0; release → IDLE.
- PUSH_I: start with opcode=00001, full=0 → push=1 in cycle 1, done=1 err=0 in cycle 2, no pop/load; opcode_q=00001.
- ADD, POP_LAT=1: push_i 12 then push_i 15, then start opcode=00100 with empty=0 → pop in c1 and c4, load in c3 (load_sel=0) and c6 (load_sel=1), push in c7, done in c8, err=0; datapath stack top = 27.
- Underflow: stack holds one value, ADD → first pop in c1; empty=1 at POP2 → no second pop, done with err=1, err_code=01, no push.
- Overflow and illegal:
  - full=1, PUSH_D → push never asserted, done with err_code=10.
  - opcode=11010 → done in cycle 1, err_code=11, no strobes.
- Robustness:
  - start pulsed during ADD is ignored.
  - rstn=0 at c4 of ADD → next cycle IDLE, no done, no further strobes.
  - POP_LAT=0 ADD → done in c6.
